ram_stream_writer: RTL
======================

Name: ram_stream_writer

Overview:
- Writer-side counterpart of the ROM address-generator/read path: accepts a byte stream over a valid/ready handshake and writes it into a 512x8 distributed RAM at sequential addresses.
- Drives the RAM write port (we/a/d) directly.
- Used to load lookup contents at runtime that the read side later scans; sits between the byte source (UART/loader) and the RAM IP.

Parameters:
ADDR_W, 9, RAM address width
DATA_W, 8, RAM data width
DEPTH, 512, number of RAM words (2**ADDR_W)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins a write burst when idle
base_addr  input  ADDR_W  first write address, latched on accepted start
len  input  ADDR_W+1  burst length in words, latched on accepted start; 0 means DEPTH
abort  input  1  terminates an active burst
in_valid  input  1  source has a byte on in_data
in_data  input  DATA_W  stream byte
in_ready  output  1  writer accepts in_data this cycle
we  output  1  RAM write enable
waddr  output  ADDR_W  RAM write address
wdata  output  DATA_W  RAM write data
busy  output  1  burst in progress
done  output  1  one-cycle pulse on normal burst completion
count  output  ADDR_W+1  words written in current/last burst

Behaviour:
- Reset (async, active-high): state IDLE; we=0, waddr=0, wdata=0, busy=0, done=0, count=0, in_ready=0; internal address and remaining-count registers 0.
- States: IDLE, WRITE, DONE.
- IDLE: in_ready=0, busy=0. start=1 -> latch base_addr into cur_addr; latch len (0 -> DEPTH) into remaining; count=0; next state WRITE.
- WRITE: busy=1. in_ready = (state==WRITE) && !abort; this term is combinational.
- Handshake: a transfer occurs when in_valid && in_ready.
- On a transfer: next cycle we=1, waddr=cur_addr, wdata=in_data. Write latency is one cycle from acceptance; outputs are registered.
- Also on a transfer: cur_addr <= cur_addr+1 modulo DEPTH (511 -> 0 wrap, no error); count+1; remaining-1.
- we=0 in any cycle following no transfer. waddr/wdata hold their last values.
- Transfer with remaining==1 -> next state DONE. in_ready is therefore low in the following cycle, so no overrun.
- DONE: lasts one cycle. done=1, aligned with the we of the final word. busy stays 1. Next state IDLE.
- abort in WRITE -> next state IDLE; no transfer in that cycle; done not asserted. A we for a byte accepted in the previous cycle still issues. count keeps the value reached.
- start while WRITE/DONE is ignored. abort in IDLE/DONE is ignored. start and abort together in IDLE: start wins.
- in_valid low in WRITE stalls indefinitely, with no timeout.
- Reset mid-burst: immediate return to reset values. A partially written region is left as is.
- count remains readable in IDLE until the next accepted start.

Optional Feature:
- Macro RAM_STREAM_WRITER_CSUM_EN.
- Defined: adds output csum (DATA_W), a running modulo-256 sum of every accepted byte. Cleared to 0 on accepted start and on reset. Updated in the same cycle as we. Final value is stable when done=1 and held in IDLE.
- Undefined: no csum port and no summing logic.

Decomposition:
- Package ram_stream_writer_pkg: ADDR_W, DATA_W, DEPTH constants; state enum typedef {IDLE, WRITE, DONE}; word and address typedefs.
- One sub-module, ram_wr_addr_gen: loadable wrapping address counter with load (base_addr) and inc inputs. It mirrors the read-side address generator.
- FSM, handshake and output registers stay in the top module.

Test Plan:
- Reset mid-burst: base=0x000, len=4, in_valid held high, rst asserted after 2 words -> outputs immediately 0, state IDLE, no done.
- Basic burst: base=0x010, len=4, bytes A0..A3 with in_valid always high -> we high on 4 consecutive cycles, waddr 0x010..0x013, wdata A0..A3; done coincident with 4th we; count=4; in_ready low after 4th accept.
- Wrap: base=0x1FE, len=4 -> waddr sequence 0x1FE, 0x1FF, 0x000, 0x001.
- Backpressure/gaps: len=3, in_valid toggling 1,0,1,0,1 -> exactly 3 we pulses, one cycle after each valid; no we in gap cycles.
- Abort and start-while-busy: len=8, abort after 3 accepts, start pulsed during burst -> 3 we pulses, done never asserted, count=3, start ignored.
- len=0 and checksum: len=0 with 512 bytes of value 0x01 -> 512 writes covering 0x000..0x1FF, done after the 512th; with CSUM_EN, csum=0x00 (512 mod 256). A second burst of bytes 0x10, 0x20, 0x30 gives csum=0x60.

Source files
------------

// File: rtl/ram_stream_writer_pkg.sv
// Shared constants, types and FSM encoding for the RAM stream writer.
// The optional checksum output is controlled by RAM_STREAM_WRITER_CSUM_EN in the top module.
package ram_stream_writer_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W:0]   cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // DEPTH is a power of two, so the natural overflow of addr_t is the wrap.
  function automatic addr_t next_addr(input addr_t a);
    return a + addr_t'(1);
  endfunction

  // A requested length of zero stands for a full-RAM burst.
  function automatic cnt_t burst_len(input cnt_t l);
    return (l == '0) ? cnt_t'(DEPTH) : l;
  endfunction

endpackage

// File: rtl/ram_wr_addr_gen.sv
// Loadable wrapping write-address counter; mirrors the read-side address generator.
// load has priority over inc; the counter wraps from DEPTH-1 back to 0.
module ram_wr_addr_gen
  import ram_stream_writer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  addr_t load_addr,
  input  logic  inc,
  output addr_t addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_addr;
    end else if (inc) begin
      addr <= next_addr(addr);
    end
  end

endmodule

// File: rtl/ram_stream_writer.sv
// Accepts a valid/ready byte stream and writes it to a 512x8 RAM at sequential addresses.
// Define RAM_STREAM_WRITER_CSUM_EN to add the running modulo-256 checksum output csum.
module ram_stream_writer
  import ram_stream_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
`ifdef RAM_STREAM_WRITER_CSUM_EN
  output logic [DATA_W-1:0] csum,
`endif
  output state_t            dbg_state,
  output logic [ADDR_W:0]   count
);

  // Handshake: a byte moves when in_valid && in_ready on a rising edge. in_ready is
  // combinational (WRITE and no abort); the source may hold in_valid low indefinitely.

  state_t state, state_next;
  addr_t  cur_addr;
  cnt_t   remaining;
  logic   start_ok;
  logic   xfer;
  logic   last;

  assign start_ok  = (state == IDLE) && start;
  assign in_ready  = (state == WRITE) && !abort;
  assign xfer      = in_valid && in_ready;
  assign last      = (remaining == cnt_t'(1));
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  ram_wr_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (start_ok),
    .load_addr (base_addr),
    .inc       (xfer),
    .addr      (cur_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (xfer && last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Burst bookkeeping: remaining words and words written so far.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      count     <= '0;
    end else if (start_ok) begin
      remaining <= burst_len(len);
      count     <= '0;
    end else if (xfer) begin
      remaining <= remaining - cnt_t'(1);
      count     <= count + cnt_t'(1);
    end
  end

  // RAM write port: one cycle behind acceptance; address and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done  <= 1'b0;
    end else begin
      we   <= xfer;
      done <= xfer && last;
      if (xfer) begin
        waddr <= cur_addr;
        wdata <= in_data;
      end
    end
  end

`ifdef RAM_STREAM_WRITER_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (xfer) begin
      csum <= csum + in_data;
    end
  end
`endif

endmodule
